instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/instruction_fetch.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch-state encoding,
// instruction field positions and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between instruction memory and the fetch outputs.
// Each entry carries {pc, instr}; flush empties it in one cycle.
module fetch_buffer #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] data_reg;
            // Write the slot the write pointer selects
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    data_reg <= RESET_VAL;
                else if (push_ok && (wr_ptr_reg == 1'(gi)))
                    data_reg <= wr_data;
            end
        end
    endgenerate

    assign rd_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

    // Pointer and occupancy bookkeeping; flush discards everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests words from instruction memory, presents
// them to decode with a valid/ready handshake and handles branch redirects.
// Optional macro IF_PREFETCH_EN adds a 2-entry prefetch buffer so fetching
// overlaps with decode; without it a single holding register is used.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] target_reg, target_next;
    logic              squash_reg, squash_next;
    logic [ADDR_W-1:0] redirect_pc;
    logic              handshake;
    logic              accept;

    // Redirects always land on a word boundary
    assign redirect_pc = branch_target & ~ADDR_W'(3);
    assign handshake   = instr_valid && instr_ready;
    assign imem_addr   = fetch_pc_reg;

`ifdef IF_PREFETCH_EN
    logic [ADDR_W+31:0] head;
    logic               buf_full;
    logic               buf_empty;
    logic               buf_one;

    fetch_buffer #(
        .DATA_W    (ADDR_W + 32),
        .RESET_VAL ({RESET_PC, 32'h0})
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .pop     (handshake),
        .flush   (branch_taken),
        .wr_data ({fetch_pc_reg, imem_rdata}),
        .rd_data (head),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign buf_one = !buf_empty && !buf_full;
    assign instr   = head[31:0];
    assign pc_out  = head[ADDR_W+31:32];
`else
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] pc_out_reg;

    // Holding register loads only on an accepted (non-squashed) response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg  <= 32'h0;
            pc_out_reg <= RESET_PC;
        end else if (accept) begin
            instr_reg  <= imem_rdata;
            pc_out_reg <= fetch_pc_reg;
        end
    end

    assign instr  = instr_reg;
    assign pc_out = pc_out_reg;
`endif

    assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
    assign pc_plus4 = pc_out + ADDR_W'(4);

    // State register and fetch bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            target_reg   <= RESET_PC;
            squash_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            target_reg   <= target_next;
            squash_reg   <= squash_next;
        end
    end

    // Next-state logic: request sequencing, squash tracking and redirects
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        target_next   = target_reg;
        squash_next   = squash_reg;
        accept        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
                if (branch_taken)
                    fetch_pc_next = redirect_pc;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    squash_next = 1'b0;
                    if (branch_taken) begin
                        fetch_pc_next = redirect_pc;
                    end else if (squash_reg) begin
                        // Stale response for the pre-redirect address
                        fetch_pc_next = target_reg;
                    end else begin
                        accept = 1'b1;
`ifdef IF_PREFETCH_EN
                        fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
                        if (buf_one && !handshake)
                            state_next = ST_HOLD;
`else
                        state_next = ST_HOLD;
`endif
                    end
                end else if (branch_taken) begin
                    // Address must stay put until memory answers
                    squash_next = 1'b1;
                    target_next = redirect_pc;
                end
            end
            ST_HOLD: begin
`ifdef IF_PREFETCH_EN
                if (branch_taken) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = ST_REQ;
                end else if (handshake) begin
                    state_next = ST_REQ;
                end
`else
                if (branch_taken || handshake) begin
                    state_next    = ST_REQ;
                    fetch_pc_next = branch_taken ? redirect_pc
                                                 : fetch_pc_reg + ADDR_W'(4);
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        imem_req = (state_reg == ST_REQ);
`ifdef IF_PREFETCH_EN
        instr_valid = !buf_empty;
`else
        instr_valid = (state_reg == ST_HOLD);
`endif
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder with programmable ack delay,
// scoreboard of expected {pc, instr} pushed on accepted acks and popped on
// handshakes, a redirect vector table and hand-written corner sequences.
// Build with +define+IF_PREFETCH_EN to exercise the prefetch variant.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .funct         (funct),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
    } redir_vec_t;

    exp_t        sb[$];
    logic [31:0] addr_log[$];
    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;
    int          wait_cnt = 0;
    int          ack_delay = 1;
    bit          drop_ack = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[7:2], a[27:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: handshake monitor, memory model, then advance to next negedge
    task automatic tick();
        bit   good_ack = 1'b0;
        bit   bad_ack  = 1'b0;
        exp_t e;
        if (instr_valid && instr_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                chk("unexpected_instr", instr, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("hs_instr", instr, e.ins);
                chk("hs_pc", pc_out, e.pc);
                chk("hs_opcode", 32'(opcode), 32'(e.ins[31:26]));
                chk("hs_funct", 32'(funct), 32'(e.ins[5:0]));
                chk("hs_pc_plus4", pc_plus4, e.pc + 32'd4);
                $display("txn pc=%h instr=%h", pc_out, instr);
            end
        end
        if (branch_taken) begin
`ifdef IF_PREFETCH_EN
            sb.delete();
`else
            if (instr_valid && !instr_ready && sb.size() > 0)
                void'(sb.pop_front());
`endif
        end
        if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                addr_log.push_back(imem_addr);
                wait_cnt   = 0;
                if (drop_ack || branch_taken) begin
                    drop_ack = 1'b0;
                    bad_ack  = 1'b1;
                end else begin
                    sb.push_back('{pc: imem_addr, ins: mem_word(imem_addr)});
                    good_ack = 1'b1;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
                if (branch_taken)
                    drop_ack = 1'b1;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
        @(negedge clk);
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        if (good_ack)
            chk("ack_latency_valid", 32'(instr_valid), 32'd1);
        if (bad_ack)
            chk("dropped_not_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            if (instr_valid)
                return;
            tick();
        end
        chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic run_hs(input int n, input int max);
        int goal;
        goal = hs_count + n;
        for (int i = 0; i < max; i++) begin
            if (hs_count >= goal)
                return;
            tick();
        end
        chk("handshake_timeout", 32'(hs_count), 32'(goal));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[4];
        vecs[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100};
        vecs[1] = '{target: 32'h0000_2003, exp_addr: 32'h0000_2000};
        vecs[2] = '{target: 32'h0000_0007, exp_addr: 32'h0000_0004};
        vecs[3] = '{target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        rst = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

`ifdef IF_PREFETCH_EN
        // Continuous streaming, then a flush on redirect
        ack_delay   = 0;
        instr_ready = 1'b1;
        wait_valid(10);
        for (int i = 0; i < 10; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        tick();
        wait_valid(10);
        chk("flush_first_pc", pc_out, 32'h0000_0500);
        chk("flush_first_instr", instr, mem_word(32'h0000_0500));
        run_hs(4, 20);
`else
        // Straight-line fetch with single-cycle memory
        instr_ready = 1'b1;
        run_hs(3, 40);
        chk("seq_addr0", addr_log[0], 32'h0);
        chk("seq_addr1", addr_log[1], 32'h4);
        chk("seq_addr2", addr_log[2], 32'h8);

        // Backpressure in HOLD
        instr_ready = 1'b0;
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", instr, sb[0].ins);
            chk("bp_pc", pc_out, sb[0].pc);
            chk("bp_opcode", 32'(opcode), 32'(sb[0].ins[31:26]));
            chk("bp_no_req", 32'(imem_req), 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();

        // Redirect coincident with a handshake, from the vector table
        for (int i = 0; i < 4; i++) begin
            instr_ready = 1'b0;
            wait_valid(10);
            instr_ready   = 1'b1;
            branch_taken  = 1'b1;
            branch_target = vecs[i].target;
            tick();
            chk("redir_req", 32'(imem_req), 32'd1);
            chk("redir_addr", imem_addr, vecs[i].exp_addr);
        end

        // PC wrap at the top of the address space
        instr_ready = 1'b0;
        wait_valid(10);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        instr_ready = 1'b1;
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Redirect while a slow request is outstanding
        ack_delay     = 3;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        tick();
        for (int i = 0; i < 10 && drop_ack; i++) begin
            chk("squash_req_held", 32'(imem_req), 32'd1);
            chk("squash_addr_held", imem_addr, 32'h0);
            tick();
        end
        chk("squash_next_addr", imem_addr, 32'h0000_0100);
        ack_delay = 1;
        run_hs(1, 20);

        // Redirect in the same cycle as the ack
        for (int i = 0; i < 10 && !(imem_req && wait_cnt >= ack_delay); i++)
            tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        tick();
        chk("ack_redir_req", 32'(imem_req), 32'd1);
        chk("ack_redir_addr", imem_addr, 32'h0000_0040);
        run_hs(1, 20);

        // Redirect in HOLD drops the held instruction
        instr_ready = 1'b0;
        wait_valid(10);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        chk("hold_redir_valid", 32'(instr_valid), 32'd0);
        chk("hold_redir_addr", imem_addr, 32'h0000_0300);
        instr_ready = 1'b1;
        run_hs(1, 20);

        // Reset mid-request, then a stray ack while idle
        instr_ready = 1'b0;
        ack_delay   = 3;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_ack_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        sb.delete();
        wait_cnt    = 0;
        drop_ack    = 1'b0;
        ack_delay   = 1;
        instr_ready = 1'b1;
        run_hs(1, 20);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
